// File: rtl/fcvt_s_wu.sv
// fcvt_s_wu: unsigned 32-bit integer to IEEE-754 binary32 conversion.
// The request is registered on arrival. Three stages then follow:
// leading-one detect, normalize, round/pack.
// A result appears three edges after the edge that captured its request.
module fcvt_s_wu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_input,
    input  logic [31:0] a,
    input  logic [2:0]  rm,
    output logic        valid_output,
    output logic [31:0] y,
    output logic        nx
);

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    // capture register
    logic        v0;
    logic [31:0] a0;
    logic [2:0]  rm0;

    // stage 1: zero detect / leading-one position
    logic        v1;
    logic        zero1;
    logic [4:0]  p1;
    logic [30:0] a1;
    logic [2:0]  rm1;
    logic [4:0]  p_c;

    // stage 2: normalized fraction, guard, sticky
    logic        v2;
    logic        zero2;
    logic [2:0]  rm2;
    logic [7:0]  exp2;
    logic [22:0] frac2;
    logic        guard2;
    logic        sticky2;
    logic [30:0] norm_c;

    // stage 3: rounding
    rm_e         mode_c;
    logic        round_up_c;
    logic [23:0] sum_c;
    logic [7:0]  exp_r_c;
    logic [22:0] frac_r_c;
    logic [31:0] y_c;
    logic        nx_c;

    // Capture the request; data only loads when the request is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0  <= 1'b0;
            a0  <= '0;
            rm0 <= '0;
        end else begin
            v0 <= valid_input;
            if (valid_input) begin
                a0  <= a;
                rm0 <= rm;
            end
        end
    end

    // Position of the most-significant 1; the highest set bit wins.
    always_comb begin
        p_c = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (a0[i]) p_c = i[4:0];
        end
    end

    // Stage 1 register. Bit 31 of the operand is dropped here.
    // Only the bits below the leading one survive normalization.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            zero1 <= 1'b0;
            p1    <= '0;
            a1    <= '0;
            rm1   <= '0;
        end else begin
            v1 <= v0;
            if (v0) begin
                zero1 <= (a0 == 32'd0);
                p1    <= p_c;
                a1    <= a0[30:0];
                rm1   <= rm0;
            end
        end
    end

    // The shift places the bit just below the leading one at bit 30.
    assign norm_c = a1 << (5'd31 - p1);

    // Stage 2 register: fraction, guard bit, sticky bit, biased exponent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            zero2   <= 1'b0;
            rm2     <= '0;
            exp2    <= '0;
            frac2   <= '0;
            guard2  <= 1'b0;
            sticky2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                zero2   <= zero1;
                rm2     <= rm1;
                exp2    <= 8'd127 + {3'b000, p1};
                frac2   <= norm_c[30:8];
                guard2  <= norm_c[7];
                sticky2 <= |norm_c[6:0];
            end
        end
    end

    // Decode the rounding mode; unused encodings fall back to RNE.
    always_comb begin
        mode_c = RM_RNE;
        case (rm2)
            3'b001:  mode_c = RM_RTZ;
            3'b010:  mode_c = RM_RDN;
            3'b011:  mode_c = RM_RUP;
            3'b100:  mode_c = RM_RMM;
            default: mode_c = RM_RNE;
        endcase
    end

    // Round-up decision, fraction carry into exponent, pack.
    always_comb begin
        round_up_c = 1'b0;
        case (mode_c)
            RM_RNE:  round_up_c = guard2 & (sticky2 | frac2[0]);
            RM_RTZ:  round_up_c = 1'b0;
            RM_RDN:  round_up_c = 1'b0;
            RM_RUP:  round_up_c = guard2 | sticky2;
            RM_RMM:  round_up_c = guard2;
            default: round_up_c = 1'b0;
        endcase
        sum_c    = {1'b0, frac2} + {23'd0, round_up_c};
        frac_r_c = sum_c[23] ? '0 : sum_c[22:0];
        exp_r_c  = exp2 + {7'd0, sum_c[23]};
        y_c      = zero2 ? '0 : {1'b0, exp_r_c, frac_r_c};
        nx_c     = ~zero2 & (guard2 | sticky2);
    end

    // Output register: y and nx hold their values between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_output <= 1'b0;
            y            <= '0;
            nx           <= 1'b0;
        end else begin
            valid_output <= v2;
            if (v2) begin
                y  <= y_c;
                nx <= nx_c;
            end
        end
    end

endmodule

// File: tb/tb_fcvt_s_wu.sv
// Self-checking bench for fcvt_s_wu.
// Inputs come from a vector table plus random operands checked against a model.
// A scoreboard compares each result in the cycle it must appear.
module tb_fcvt_s_wu;

    logic        clk;
    logic        rst_n;
    logic        valid_input;
    logic [31:0] a;
    logic [2:0]  rm;
    logic        valid_output;
    logic [31:0] y;
    logic        nx;

    fcvt_s_wu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_input  (valid_input),
        .a            (a),
        .rm           (rm),
        .valid_output (valid_output),
        .y            (y),
        .nx           (nx)
    );

    typedef struct {
        logic [31:0] a;
        logic [2:0]  rm;
        logic [31:0] y;
        logic        nx;
    } vec_t;

    typedef struct {
        logic [31:0] y;
        logic        nx;
        int          due;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    int          cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;
    logic [31:0] last_y = '0;
    logic        last_nx = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: integer shift/remainder arithmetic.
    function automatic logic [32:0] model(input logic [31:0] av, input logic [2:0] rmv);
        int          p;
        int          sh;
        logic [63:0] kept;
        logic [63:0] rem;
        logic [63:0] half;
        logic        g;
        logic        s;
        logic        up;
        logic [7:0]  e;
        if (av == 32'd0) return 33'd0;
        p = 0;
        for (int i = 31; i >= 0; i--) begin
            if (av[i]) begin
                p = i;
                break;
            end
        end
        e = 8'(127 + p);
        if (p <= 23) begin
            kept = {32'd0, av} << (23 - p);
            g = 1'b0;
            s = 1'b0;
        end else begin
            sh   = p - 23;
            kept = {32'd0, av} >> sh;
            rem  = {32'd0, av} & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            g    = (rem >= half);
            s    = ((rem & (half - 64'd1)) != 64'd0);
        end
        case (rmv)
            3'd1, 3'd2: up = 1'b0;
            3'd3:       up = g | s;
            3'd4:       up = g;
            default:    up = g & (s | kept[0]);
        endcase
        kept = kept + {63'd0, up};
        if (kept[24]) begin
            kept = kept >> 1;
            e    = e + 8'd1;
        end
        return {g | s, 1'b0, e, kept[22:0]};
    endfunction

    task automatic send(input logic [31:0] av, input logic [2:0] rmv,
                        input logic [31:0] ey, input logic enx);
        exp_t e;
        @(negedge clk);
        #1;
        valid_input = 1'b1;
        a  = av;
        rm = rmv;
        e.y = ey;
        e.nx = enx;
        e.due = cyc + 4;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        valid_input = 1'b0;
        a  = $urandom;
        rm = 3'($urandom_range(0, 7));
    endtask

    // Each negedge checks the output against the scoreboard head.
    // Without a due result, the output must be idle and hold its last values.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("valid_output_result", {31'd0, valid_output}, 32'd1);
                chk("y", y, e.y);
                chk("nx", {31'd0, nx}, {31'd0, e.nx});
                last_y  = e.y;
                last_nx = e.nx;
            end else begin
                chk("valid_output_idle", {31'd0, valid_output}, 32'd0);
                chk("y_hold", y, last_y);
                chk("nx_hold", {31'd0, nx}, {31'd0, last_nx});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d results outstanding", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic [32:0] m;
        logic [31:0] ra;
        logic [2:0]  rr;

        tbl.push_back('{32'd1,          3'd0, 32'h3F800000, 1'b0});
        tbl.push_back('{32'd2,          3'd0, 32'h40000000, 1'b0});
        tbl.push_back('{32'd10,         3'd0, 32'h41200000, 1'b0});
        tbl.push_back('{32'd50,         3'd0, 32'h42480000, 1'b0});
        tbl.push_back('{32'd0,          3'd0, 32'h00000000, 1'b0});
        tbl.push_back('{32'd0,          3'd3, 32'h00000000, 1'b0});
        tbl.push_back('{32'h01000001,   3'd0, 32'h4B800000, 1'b1});
        tbl.push_back('{32'h01000001,   3'd1, 32'h4B800000, 1'b1});
        tbl.push_back('{32'h01000001,   3'd2, 32'h4B800000, 1'b1});
        tbl.push_back('{32'h01000001,   3'd3, 32'h4B800001, 1'b1});
        tbl.push_back('{32'h01000001,   3'd4, 32'h4B800001, 1'b1});
        tbl.push_back('{32'h01000001,   3'd7, 32'h4B800000, 1'b1});
        tbl.push_back('{32'hFFFFFFFF,   3'd0, 32'h4F800000, 1'b1});
        tbl.push_back('{32'hFFFFFFFF,   3'd1, 32'h4F7FFFFF, 1'b1});
        tbl.push_back('{32'hFFFFFFFF,   3'd3, 32'h4F800000, 1'b1});
        tbl.push_back('{32'hFFFFFFFF,   3'd2, 32'h4F7FFFFF, 1'b1});
        tbl.push_back('{32'hFFFFFFFF,   3'd4, 32'h4F800000, 1'b1});
        tbl.push_back('{32'h00FFFFFF,   3'd0, 32'h4B7FFFFF, 1'b0});
        tbl.push_back('{32'h01000002,   3'd0, 32'h4B800001, 1'b0});
        tbl.push_back('{32'h01000003,   3'd0, 32'h4B800002, 1'b1});
        tbl.push_back('{32'h80000000,   3'd1, 32'h4F000000, 1'b0});

        rst_n = 1'b0;
        valid_input = 1'b0;
        a  = '0;
        rm = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid_output", {31'd0, valid_output}, 32'd0);
        chk("reset_y", y, 32'd0);
        chk("reset_nx", {31'd0, nx}, 32'd0);
        #1;
        rst_n = 1'b1;

        // Table vectors, issued back-to-back.
        foreach (tbl[i]) send(tbl[i].a, tbl[i].rm, tbl[i].y, tbl[i].nx);

        // Random operands over all magnitudes and rm encodings.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom >> $urandom_range(0, 31);
            rr = 3'($urandom_range(0, 7));
            m  = model(ra, rr);
            send(ra, rr, m[31:0], m[32]);
        end

        // Gap: pulses 1,0,1 on valid_input.
        send(32'd10, 3'd0, 32'h41200000, 1'b0);
        idle();
        send(32'd50, 3'd0, 32'h42480000, 1'b0);
        repeat (6) idle();

        // Reset while two requests are in flight.
        send(32'd2, 3'd0, 32'h40000000, 1'b0);
        send(32'd1, 3'd0, 32'h3F800000, 1'b0);
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        last_y  = '0;
        last_nx = 1'b0;
        #1;
        chk("midflight_reset_valid_output", {31'd0, valid_output}, 32'd0);
        chk("midflight_reset_y", y, 32'd0);
        chk("midflight_reset_nx", {31'd0, nx}, 32'd0);
        repeat (2) @(negedge clk);

        // Release with a request pending at the first active edge.
        #1;
        rst_n = 1'b1;
        valid_input = 1'b1;
        a  = 32'hFFFFFFFF;
        rm = 3'd1;
        begin
            exp_t e;
            e.y = 32'h4F7FFFFF;
            e.nx = 1'b1;
            e.due = cyc + 4;
            sb.push_back(e);
        end
        repeat (10) idle();

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
